// File: rtl/product_bcd_if.sv
// Handshake bundle between the shift-add multiplier (master) and product_bcd (slave).
// seg/an exist only when PRODUCT_BCD_SEG_EN is defined.
interface product_bcd_if;
    logic        ready;
    logic [7:0]  AQ;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
`ifdef PRODUCT_BCD_SEG_EN
    logic [6:0]  seg;
    logic [2:0]  an;
`endif

    modport master (
        output ready,
        output AQ,
        input  bcd,
        input  busy,
        input  done
`ifdef PRODUCT_BCD_SEG_EN
        ,
        input  seg,
        input  an
`endif
    );

    modport slave (
        input  ready,
        input  AQ,
        output bcd,
        output busy,
        output done
`ifdef PRODUCT_BCD_SEG_EN
        ,
        output seg,
        output an
`endif
    );
endinterface

// File: rtl/product_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock).
// Define PRODUCT_BCD_SEG_EN to add the scanned seven-segment driver (seg/an, SCAN_BITS).
module product_bcd
`ifdef PRODUCT_BCD_SEG_EN
#(
    parameter int unsigned SCAN_BITS = 10
)
`endif
(
    input  logic             clock,
    input  logic             nreset,
    product_bcd_if.slave     bus
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e      r_state;
    logic        r_rdy_q;
    logic [7:0]  r_bin;
    logic [11:0] r_work;
    logic [2:0]  r_cnt;
    logic [11:0] r_bcd;
    logic        r_busy;
    logic        r_done;

    logic        w_trigger;
    logic [11:0] w_adj;
    logic [19:0] w_shift;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign w_trigger = bus.ready & ~r_rdy_q;
    assign w_adj     = {add3(r_work[11:8]), add3(r_work[7:4]), add3(r_work[3:0])};
    assign w_shift   = {w_adj, r_bin} << 1;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= StIdle;
            r_rdy_q <= 1'b1;  // blocks a spurious trigger if ready is high out of reset
            r_bin   <= 8'h00;
            r_work  <= 12'h000;
            r_cnt   <= 3'd0;
            r_bcd   <= 12'h000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rdy_q <= bus.ready;
            r_done  <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (w_trigger) begin
                        r_bin   <= bus.AQ;
                        r_work  <= 12'h000;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= StConv;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StConv: begin
                    r_work <= w_shift[19:8];
                    r_bin  <= w_shift[7:0];
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_bcd   <= w_shift[19:8];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.bcd  = r_bcd;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

`ifdef PRODUCT_BCD_SEG_EN
    logic [SCAN_BITS+1:0] r_scan;
    logic [6:0]           r_seg;
    logic [2:0]           r_an;
    logic [1:0]           w_sel;
    logic [3:0]           w_digit;
    logic                 w_blank;
    logic [2:0]           w_an;

    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_sel = r_scan[SCAN_BITS+1:SCAN_BITS];

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b1;
        w_an    = 3'b111;
        unique case (w_sel)
            2'd0: begin
                w_an    = 3'b110;
                w_digit = r_bcd[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_an    = 3'b101;
                w_digit = r_bcd[7:4];
                w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            2'd2: begin
                w_an    = 3'b011;
                w_digit = r_bcd[11:8];
                w_blank = (r_bcd[11:8] == 4'd0);
            end
            2'd3: begin
                w_an    = 3'b111;
                w_blank = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_scan <= '0;
            r_seg  <= 7'h7F;
            r_an   <= 3'b111;
        end else begin
            r_scan <= r_scan + 1'b1;
            r_seg  <= w_blank ? 7'h7F : seg7(w_digit);
            r_an   <= w_an;
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
`endif

endmodule

// File: tb/tb_product_bcd.sv
// Self-checking bench for product_bcd: directed scenarios plus random conversions
// against a decimal-arithmetic reference.
module tb_product_bcd;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    product_bcd_if bus();

`ifdef PRODUCT_BCD_SEG_EN
    product_bcd #(.SCAN_BITS(2)) dut (.clock(clock), .nreset(nreset), .bus(bus));
`else
    product_bcd dut (.clock(clock), .nreset(nreset), .bus(bus));
`endif

    always #5 clock = ~clock;

    // Counts done pulses as seen by a downstream register.
    always @(posedge clock) if (bus.done === 1'b1) done_cnt++;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic start(input logic [7:0] v);
        @(negedge clock);
        bus.AQ    = v;
        bus.ready = 1'b1;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        bus.ready = 1'b0;
        bus.AQ    = 8'h00;
        repeat (3) @(negedge clock);
        checks++; if (bus.bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bus.bcd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
`ifdef PRODUCT_BCD_SEG_EN
        checks++; if (bus.an !== 3'b111) begin errors++; $display("FAIL reset_an got %b want 111", bus.an); end
        checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
`endif
        nreset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic();
        done_cnt = 0;
        start(8'h23);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++; $display("FAIL basic_busy cycle %0d got busy=%b done=%b want 1/0", i, bus.busy, bus.done);
            end
            if (i == 3) begin
                checks++;
                if (bus.bcd !== 12'h000) begin errors++; $display("FAIL basic_midconv_bcd got %h want 000", bus.bcd); end
            end
        end
        @(negedge clock);
        bus.ready = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_cycle got done=%b busy=%b want 1/0", bus.done, bus.busy);
        end
        checks++; if (bus.bcd !== 12'h035) begin errors++; $display("FAIL basic_bcd got %h want 035", bus.bcd); end
        @(negedge clock);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_extremes();
        bit got;
        done_cnt = 0;
        start(8'hFF);
        wait_done(got);
        checks++; if (!got || bus.bcd !== 12'h255) begin errors++; $display("FAIL ext_ff got %h (done=%b) want 255", bus.bcd, got); end
        bus.ready = 1'b0;
        repeat (2) @(negedge clock);
        start(8'h00);
        wait_done(got);
        checks++; if (!got || bus.bcd !== 12'h000) begin errors++; $display("FAIL ext_00 got %h (done=%b) want 000", bus.bcd, got); end
        bus.ready = 1'b0;
        @(negedge clock);
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL ext_done_count got %0d want 2", done_cnt); end
    endtask

    task automatic test_no_retrigger();
        done_cnt = 0;
        start(8'h24);
        repeat (40) @(negedge clock);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL hold_done_count got %0d want 1", done_cnt); end
        checks++; if (bus.bcd !== 12'h036) begin errors++; $display("FAIL hold_bcd got %h want 036", bus.bcd); end
        bus.ready = 1'b0;
        nreset    = 1'b0;
        @(negedge clock);
        bus.ready = 1'b1;
        bus.AQ    = 8'h55;
        @(negedge clock);
        nreset   = 1'b1;
        done_cnt = 0;
        repeat (15) @(negedge clock);
        checks++;
        if (done_cnt !== 0 || bus.bcd !== 12'h000) begin
            errors++; $display("FAIL ready_at_reset got done_cnt=%0d bcd=%h want 0/000", done_cnt, bus.bcd);
        end
        bus.ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_ignored_during_conv();
        bit got;
        done_cnt = 0;
        start(8'h64);
        @(negedge clock);
        bus.ready = 1'b0;
        repeat (3) @(negedge clock);
        bus.ready = 1'b1;
        bus.AQ    = 8'h09;
        wait_done(got);
        checks++; if (!got || bus.bcd !== 12'h100) begin errors++; $display("FAIL ignore_bcd got %h (done=%b) want 100", bus.bcd, got); end
        repeat (12) @(negedge clock);
        checks++;
        if (done_cnt !== 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ignore_single_done got done_cnt=%0d busy=%b want 1/0", done_cnt, bus.busy);
        end
        bus.ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        start(8'hC8);
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1 nreset = 1'b0;
        #1;
        checks++;
        if (bus.bcd !== 12'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midreset_async got bcd=%h busy=%b done=%b want 000/0/0", bus.bcd, bus.busy, bus.done);
        end
        bus.ready = 1'b0;
        @(negedge clock);
        nreset   = 1'b1;
        done_cnt = 0;
        repeat (15) @(negedge clock);
        checks++;
        if (done_cnt !== 0 || bus.bcd !== 12'h000) begin
            errors++; $display("FAIL midreset_no_resume got done_cnt=%0d bcd=%h want 0/000", done_cnt, bus.bcd);
        end
    endtask

    task automatic test_random();
        bit got;
        int v;
        for (int n = 0; n < 20; n++) begin
            v = int'($urandom_range(0, 255));
            start(8'(v));
            wait_done(got);
            checks++;
            if (!got || bus.bcd !== ref_bcd(v)) begin
                errors++; $display("FAIL random_%0d got %h (done=%b) want %h", v, bus.bcd, got, ref_bcd(v));
            end
            bus.ready = 1'b0;
            repeat (int'($urandom_range(1, 3))) @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        int a, b;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        done_cnt = 0;
        start(8'(a));
        @(negedge clock);
        bus.ready = 1'b0;
        wait_done(got);
        checks++; if (!got || bus.bcd !== ref_bcd(a)) begin errors++; $display("FAIL b2b_first got %h want %h", bus.bcd, ref_bcd(a)); end
        bus.AQ    = 8'(b);
        bus.ready = 1'b1;
        @(negedge clock);
        bus.ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.bcd !== ref_bcd(a)) begin
            errors++; $display("FAIL b2b_restart got busy=%b bcd=%h want 1/%h", bus.busy, bus.bcd, ref_bcd(a));
        end
        wait_done(got);
        checks++; if (!got || bus.bcd !== ref_bcd(b)) begin errors++; $display("FAIL b2b_second got %h want %h", bus.bcd, ref_bcd(b)); end
        @(negedge clock);
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    endtask

`ifdef PRODUCT_BCD_SEG_EN
    task automatic test_seg();
        bit got;
        bit seen_u, seen_t, seen_h;
        seen_u = 0; seen_t = 0; seen_h = 0;
        start(8'h23);
        wait_done(got);
        bus.ready = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            case (bus.an)
                3'b110: begin
                    seen_u = 1;
                    checks++; if (bus.seg !== 7'b0010010) begin errors++; $display("FAIL seg_units got %b want 0010010", bus.seg); end
                end
                3'b101: begin
                    seen_t = 1;
                    checks++; if (bus.seg !== 7'b0110000) begin errors++; $display("FAIL seg_tens got %b want 0110000", bus.seg); end
                end
                3'b011: begin
                    seen_h = 1;
                    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL seg_hund_blank got %b want 1111111", bus.seg); end
                end
                3'b111: ;
                default: begin
                    checks++; errors++; $display("FAIL seg_an_pattern got %b want one-low or 111", bus.an);
                end
            endcase
        end
        checks++;
        if (!(seen_u && seen_t && seen_h)) begin
            errors++; $display("FAIL seg_scan_cover got u=%b t=%b h=%b want 1/1/1", seen_u, seen_t, seen_h);
        end
    endtask
`endif

    initial begin
        bus.ready = 1'b0;
        bus.AQ    = 8'h00;
        test_reset();
        test_basic();
        test_extremes();
        test_no_retrigger();
        test_ignored_during_conv();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef PRODUCT_BCD_SEG_EN
        test_seg();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
